// File: rtl/mw_eeprom_pkg.sv
// Shared constants for the 93C46-style (x8, 128 B) Microwire EEPROM responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mw_eeprom_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    // Two-bit opcodes that follow the start bit
    localparam logic [1:0] OP_EXT   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_ERASE = 2'b11;

    // Extended sub-codes carried in ADDR[6:5] when the opcode is OP_EXT
    localparam logic [1:0] EXT_EWDS = 2'b00;
    localparam logic [1:0] EXT_WRAL = 2'b01;
    localparam logic [1:0] EXT_ERAL = 2'b10;
    localparam logic [1:0] EXT_EWEN = 2'b11;

    // Command FSM states
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_OPC     = 3'd2;
    localparam logic [2:0] ST_ADDR    = 3'd3;
    localparam logic [2:0] ST_RD_OUT  = 3'd4;
    localparam logic [2:0] ST_DATA_IN = 3'd5;
    localparam logic [2:0] ST_EXEC    = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

endpackage

// File: rtl/microwire_eeprom_emu_if.sv
// Bundle of the Microwire pins and the fabric host port of the EEPROM emulator.
// Latency: n/a (wires only).
// Backpressure: none; the host port is a plain strobe, the Microwire side is master-clocked.
// master: drives EEPROM_CS/SK/DI and HOST_WE/ADDR/WD; observes EEPROM_DO, HOST_RD, BUSY_OUT.
// slave : the emulator, the opposite direction.
interface microwire_eeprom_emu_if;
    import mw_eeprom_pkg::*;

    logic              EEPROM_CS;
    logic              EEPROM_SK;
    logic              EEPROM_DI;
    logic              EEPROM_DO;
    logic              HOST_WE;
    logic [ADDR_W-1:0] HOST_ADDR;
    logic [DATA_W-1:0] HOST_WD;
    logic [DATA_W-1:0] HOST_RD;
    logic              BUSY_OUT;

    modport master (
        output EEPROM_CS, EEPROM_SK, EEPROM_DI, HOST_WE, HOST_ADDR, HOST_WD,
        input  EEPROM_DO, HOST_RD, BUSY_OUT
    );

    modport slave (
        input  EEPROM_CS, EEPROM_SK, EEPROM_DI, HOST_WE, HOST_ADDR, HOST_WD,
        output EEPROM_DO, HOST_RD, BUSY_OUT
    );

endinterface

// File: rtl/mw_sync_edge.sv
// Brings the asynchronous Microwire CS/SK/DI into the CLK domain; flags SK rising edges.
// Latency: 2 CLK for CS/DI, SK rise pulse valid 2 CLK after the pin edge.
// Backpressure: none.
// Ports: CLK/RST, i_cs/i_sk/i_di raw pins, o_cs/o_di synchronised levels, o_sk_rise one-cycle pulse.
module mw_sync_edge (
    input  logic CLK,
    input  logic RST,
    input  logic i_cs,
    input  logic i_sk,
    input  logic i_di,
    output logic o_cs,
    output logic o_di,
    output logic o_sk_rise
);

    logic [1:0] r_cs_ff;
    logic [1:0] r_sk_ff;
    logic [1:0] r_di_ff;
    logic       r_sk_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cs_ff <= 2'b00;
            r_sk_ff <= 2'b00;
            r_di_ff <= 2'b00;
            r_sk_d  <= 1'b0;
        end else begin
            r_cs_ff <= {r_cs_ff[0], i_cs};
            r_sk_ff <= {r_sk_ff[0], i_sk};
            r_di_ff <= {r_di_ff[0], i_di};
            r_sk_d  <= r_sk_ff[1];
        end
    end

    // DI travels through the same two stages as SK, so the bit seen at an
    // SK rise is the one the master set up before that rise.
    assign o_cs      = r_cs_ff[1];
    assign o_di      = r_di_ff[1];
    assign o_sk_rise = r_sk_ff[1] & ~r_sk_d;

endmodule

// File: rtl/microwire_eeprom_emu.sv
// 93C46-compatible (x8, 128 B) Microwire EEPROM responder with a fabric host port.
// Latency: DO updates 3 CLK after an SK rise; HOST_RD is mem[HOST_ADDR] one CLK later.
// Backpressure: none; commands arriving while busy are held off in START until the busy timer expires.
// Ports: CLK, RST (sync, active high), bus (slave modport: Microwire pins, host port, BUSY_OUT).
module microwire_eeprom_emu #(
    parameter logic [15:0] BUSY_CYCLES = 16'd200,
    parameter logic        WP_DEFAULT  = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST,
    microwire_eeprom_emu_if.slave bus
);
    import mw_eeprom_pkg::*;

    logic w_cs;
    logic w_di;
    logic w_sk_rise;

    mw_sync_edge u_sync (
        .CLK       (CLK),
        .RST       (RST),
        .i_cs      (bus.EEPROM_CS),
        .i_sk      (bus.EEPROM_SK),
        .i_di      (bus.EEPROM_DI),
        .o_cs      (w_cs),
        .o_di      (w_di),
        .o_sk_rise (w_sk_rise)
    );

    logic [2:0]        r_state;
    logic [3:0]        r_bit_cnt;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [15:0]       r_busy_cnt;
    logic              r_wp;
    logic              r_do;
    logic [DATA_W-1:0] r_host_rd;
    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    logic [ADDR_W-1:0] w_addr_nxt;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [DATA_W-1:0] w_data_nxt;
    logic              w_busy;
    logic [15:0]       w_busy_nxt;
    logic              w_is_prog;
    logic              w_mw_we;
    logic              w_mw_all;
    logic [DATA_W-1:0] w_mw_wd;
    logic              w_set_wp;
    logic              w_clr_wp;

    assign w_addr_nxt = {r_addr[ADDR_W-2:0], w_di};
    assign w_addr_inc = r_addr + 7'd1;
    assign w_data_nxt = {r_data[DATA_W-2:0], w_di};
    assign w_busy     = (r_busy_cnt != 16'd0);

    // Command execution happens in the single EXEC cycle following the last bit.
    always_comb begin
        w_is_prog = 1'b0;
        w_mw_all  = 1'b0;
        w_mw_wd   = r_data;
        w_set_wp  = 1'b0;
        w_clr_wp  = 1'b0;
        if (r_state == ST_EXEC) begin
            case (r_op)
                OP_WRITE: w_is_prog = 1'b1;
                OP_ERASE: begin
                    w_is_prog = 1'b1;
                    w_mw_wd   = 8'hFF;
                end
                OP_EXT: begin
                    case (r_addr[6:5])
                        EXT_EWEN: w_clr_wp = 1'b1;
                        EXT_EWDS: w_set_wp = 1'b1;
                        EXT_ERAL: begin
                            w_is_prog = 1'b1;
                            w_mw_all  = 1'b1;
                            w_mw_wd   = 8'hFF;
                        end
                        default: begin   // WRAL
                            w_is_prog = 1'b1;
                            w_mw_all  = 1'b1;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Write-protected program/erase commands are decoded but leave no trace.
    assign w_mw_we = w_is_prog & ~r_wp;

    always_comb begin
        w_busy_nxt = w_busy ? (r_busy_cnt - 16'd1) : 16'd0;
        if (w_mw_we) begin
            w_busy_nxt = BUSY_CYCLES;
        end
    end

    // Array is deliberately not reset so contents survive RST.
    // Microwire write is last so it wins over a host write to the same byte.
    always_ff @(posedge CLK) begin
        if (bus.HOST_WE) begin
            r_mem[bus.HOST_ADDR] <= bus.HOST_WD;
        end
        if (w_mw_we) begin
            if (w_mw_all) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_mem[i[ADDR_W-1:0]] <= w_mw_wd;
                end
            end else begin
                r_mem[r_addr] <= w_mw_wd;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_host_rd <= '0;
        end else begin
            r_host_rd <= r_mem[bus.HOST_ADDR];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 4'd0;
            r_op       <= 2'b00;
            r_addr     <= '0;
            r_data     <= '0;
            r_busy_cnt <= 16'd0;
            r_wp       <= WP_DEFAULT;
            r_do       <= 1'b1;
        end else begin
            // The busy timer runs independently of CS.
            r_busy_cnt <= w_busy_nxt;
            if (w_clr_wp) r_wp <= 1'b0;
            if (w_set_wp) r_wp <= 1'b1;

            if (!w_cs) begin
                r_state   <= ST_IDLE;
                r_do      <= 1'b1;
                r_bit_cnt <= 4'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_START;
                        r_do    <= (w_busy_nxt == 16'd0);
                    end
                    ST_START: begin
                        // DO reports ready/busy until a start bit is taken;
                        // SK edges are not consumed while busy.
                        r_do <= (w_busy_nxt == 16'd0);
                        if (!w_busy && w_sk_rise && w_di) begin
                            r_state   <= ST_OPC;
                            r_bit_cnt <= 4'd0;
                        end
                    end
                    ST_OPC: begin
                        if (w_sk_rise) begin
                            r_op <= {r_op[0], w_di};
                            if (r_bit_cnt == 4'd1) begin
                                r_state   <= ST_ADDR;
                                r_bit_cnt <= 4'd0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (w_sk_rise) begin
                            r_addr <= w_addr_nxt;
                            if (r_bit_cnt == 4'd6) begin
                                r_bit_cnt <= 4'd0;
                                case (r_op)
                                    OP_READ: begin
                                        r_do    <= 1'b0;   // dummy bit
                                        r_data  <= r_mem[w_addr_nxt];
                                        r_state <= ST_RD_OUT;
                                    end
                                    OP_WRITE: r_state <= ST_DATA_IN;
                                    OP_ERASE: r_state <= ST_EXEC;
                                    default: begin
                                        r_state <= (w_addr_nxt[6:5] == EXT_WRAL) ? ST_DATA_IN : ST_EXEC;
                                    end
                                endcase
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_DATA_IN: begin
                        if (w_sk_rise) begin
                            r_data <= w_data_nxt;
                            if (r_bit_cnt == 4'd7) begin
                                r_state   <= ST_EXEC;
                                r_bit_cnt <= 4'd0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_RD_OUT: begin
                        if (w_sk_rise) begin
                            r_do <= r_data[DATA_W-1];
                            if (r_bit_cnt == 4'd7) begin
                                // Sequential read: prefetch the next byte, wrapping at 127.
                                r_addr    <= w_addr_inc;
                                r_data    <= r_mem[w_addr_inc];
                                r_bit_cnt <= 4'd0;
                            end else begin
                                r_data    <= {r_data[DATA_W-2:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_EXEC: r_state <= ST_DONE;
                    ST_DONE: ;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.EEPROM_DO = r_do;
    assign bus.HOST_RD   = r_host_rd;
    assign bus.BUSY_OUT  = w_busy;

endmodule

// File: tb/tb_microwire_eeprom_emu.sv
// Self-checking bench for the Microwire EEPROM emulator: drives the pins as a Microwire
// master at CLK/10 and compares against a byte-array reference model of the EEPROM.
// Scenarios: reset, write protect, write/read, sequential wrap, host collision, abort, busy hold-off, ERAL, random.
module tb_microwire_eeprom_emu;

    localparam logic [1:0] T_EXT   = 2'b00;
    localparam logic [1:0] T_WRITE = 2'b01;
    localparam logic [1:0] T_READ  = 2'b10;
    localparam logic [1:0] T_ERASE = 2'b11;
    localparam logic [6:0] A_EWEN  = 7'b11_00000;
    localparam logic [6:0] A_EWDS  = 7'b00_00000;
    localparam logic [6:0] A_ERAL  = 7'b10_00000;
    localparam logic [6:0] A_WRAL  = 7'b01_00000;
    localparam int SK_HALF  = 5;
    localparam int BUSY_EXP = 200;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    microwire_eeprom_emu_if bus();

    microwire_eeprom_emu #(
        .BUSY_CYCLES (16'd200),
        .WP_DEFAULT  (1'b1)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] ref_mem [0:127];
    bit         ref_wp;
    logic [7:0] rd_q [$];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    task automatic model_cmd(input logic [1:0] op, input logic [6:0] a, input logic [7:0] dat,
                             output int exp_busy);
        exp_busy = 0;
        if (op == T_EXT && a[6:5] == 2'b11) ref_wp = 1'b0;
        else if (op == T_EXT && a[6:5] == 2'b00) ref_wp = 1'b1;
        else if (!ref_wp) begin
            exp_busy = BUSY_EXP;
            if (op == T_WRITE) ref_mem[a] = dat;
            else if (op == T_ERASE) ref_mem[a] = 8'hFF;
            else if (a[6:5] == 2'b10) foreach (ref_mem[i]) ref_mem[i] = 8'hFF;
            else foreach (ref_mem[i]) ref_mem[i] = dat;
        end
    endtask

    // ---------------- pin-level helpers ----------------
    task automatic sk_bit(input logic di, output logic do_s);
        bus.EEPROM_DI = di;
        bus.EEPROM_SK = 1'b0;
        repeat (SK_HALF) @(negedge CLK);
        bus.EEPROM_SK = 1'b1;
        repeat (SK_HALF) @(negedge CLK);
        do_s = bus.EEPROM_DO;
    endtask

    task automatic cs_begin();
        @(negedge CLK);
        bus.EEPROM_SK = 1'b0;
        bus.EEPROM_DI = 1'b0;
        bus.EEPROM_CS = 1'b1;
        repeat (4) @(negedge CLK);
    endtask

    task automatic cs_end();
        bus.EEPROM_SK = 1'b0;
        repeat (2) @(negedge CLK);
        bus.EEPROM_CS = 1'b0;
        bus.EEPROM_DI = 1'b0;
        repeat (6) @(negedge CLK);
    endtask

    task automatic host_write(input logic [6:0] a, input logic [7:0] d);
        @(negedge CLK);
        bus.HOST_WE = 1'b1; bus.HOST_ADDR = a; bus.HOST_WD = d;
        @(negedge CLK);
        bus.HOST_WE = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic host_read(input logic [6:0] a, output logic [7:0] d);
        @(negedge CLK);
        bus.HOST_ADDR = a;
        @(negedge CLK);
        d = bus.HOST_RD;
    endtask

    task automatic wait_not_busy(input string name);
        int n;
        n = 0;
        while (bus.BUSY_OUT === 1'b1 && n < 400) begin
            @(negedge CLK);
            n++;
        end
        total++;
        if (bus.BUSY_OUT !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_timeout: BUSY_OUT=%b after %0d cycles, expected 0", name, bus.BUSY_OUT, n);
        end
    endtask

    // Sends a whole program/erase/ext command; returns CLK cycles BUSY_OUT was high.
    task automatic mw_program(input logic [1:0] op, input logic [6:0] a, input logic [7:0] dat,
                              input bit has_data, output int busy_cnt);
        logic [17:0] bits;
        logic d;
        int n;
        bits = {1'b1, op, a, dat};
        n = has_data ? 18 : 10;
        cs_begin();
        for (int i = 0; i < n - 1; i++) sk_bit(bits[17-i], d);
        bus.EEPROM_DI = bits[18-n];
        bus.EEPROM_SK = 1'b0;
        repeat (SK_HALF) @(negedge CLK);
        bus.EEPROM_SK = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge CLK);
            if (bus.BUSY_OUT === 1'b1) busy_cnt++;
            else if (busy_cnt > 0) break;
        end
        cs_end();
    endtask

    task automatic do_cmd(input string name, input logic [1:0] op, input logic [6:0] a, input logic [7:0] dat);
        int exp_busy, got_busy;
        bit hd;
        hd = (op == T_WRITE) || (op == T_EXT && a[6:5] == 2'b01);
        model_cmd(op, a, dat, exp_busy);
        mw_program(op, a, dat, hd, got_busy);
        total++;
        if (got_busy != exp_busy) begin
            bad++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, got_busy, exp_busy);
        end
    endtask

    task automatic mw_read(input logic [6:0] a, input int nbytes, output logic dummy);
        logic d;
        logic [7:0] b;
        rd_q.delete();
        cs_begin();
        sk_bit(1'b1, d);
        sk_bit(T_READ[1], d);
        sk_bit(T_READ[0], d);
        for (int i = 6; i >= 0; i--) sk_bit(a[i], d);
        dummy = d;
        for (int k = 0; k < nbytes; k++) begin
            b = 8'h00;
            for (int j = 0; j < 8; j++) begin
                sk_bit(1'b0, d);
                b = {b[6:0], d};
            end
            rd_q.push_back(b);
        end
        cs_end();
    endtask

    task automatic check_read(input string name, input logic [6:0] a, input int nbytes);
        logic dummy;
        int ea;
        mw_read(a, nbytes, dummy);
        total++;
        if (dummy !== 1'b0) begin
            bad++;
            $display("FAIL %s dummy_bit: got %b expected 0", name, dummy);
        end
        for (int k = 0; k < nbytes; k++) begin
            ea = (int'(a) + k) % 128;
            total++;
            if (rd_q[k] !== ref_mem[ea]) begin
                bad++;
                $display("FAIL %s read_byte[%0d] addr %0h: got %h expected %h", name, k, ea, rd_q[k], ref_mem[ea]);
            end
        end
    endtask

    task automatic check_host(input string name, input logic [6:0] a);
        logic [7:0] d;
        host_read(a, d);
        total++;
        if (d !== ref_mem[a]) begin
            bad++;
            $display("FAIL %s host_rd addr %h: got %h expected %h", name, a, d, ref_mem[a]);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RST = 1'b1;
        bus.EEPROM_CS = 1'b0; bus.EEPROM_SK = 1'b0; bus.EEPROM_DI = 1'b0;
        bus.HOST_WE = 1'b0; bus.HOST_ADDR = 7'h00; bus.HOST_WD = 8'h00;
        ref_wp = 1'b1;
        repeat (5) @(negedge CLK);
        total++;
        if (bus.EEPROM_DO !== 1'b1) begin bad++; $display("FAIL reset_do: got %b expected 1", bus.EEPROM_DO); end
        total++;
        if (bus.HOST_RD !== 8'h00) begin bad++; $display("FAIL reset_host_rd: got %h expected 00", bus.HOST_RD); end
        total++;
        if (bus.BUSY_OUT !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", bus.BUSY_OUT); end
        RST = 1'b0;
        for (int i = 0; i < 128; i++) host_write(7'(i), 8'($urandom));
        host_write(7'h10, 8'hC3);
    endtask

    task automatic test_wp_default();
        do_cmd("wp_write", T_WRITE, 7'h10, 8'h3C);
        check_host("wp_write", 7'h10);
    endtask

    task automatic test_write_read();
        do_cmd("ewen", T_EXT, A_EWEN, 8'h00);
        do_cmd("write_05", T_WRITE, 7'h05, 8'hA5);
        check_read("read_05", 7'h05, 1);
        check_host("write_05", 7'h05);
    endtask

    task automatic test_read_wrap();
        host_write(7'h7F, 8'h11);
        host_write(7'h00, 8'h22);
        check_read("wrap", 7'h7F, 2);
    endtask

    task automatic mw_write_collide(input logic [6:0] a_mw, input logic [7:0] d_mw,
                                    input logic [6:0] a_h, input logic [7:0] d_h);
        logic [17:0] bits;
        logic d;
        bit hit;
        bits = {1'b1, T_WRITE, a_mw, d_mw};
        cs_begin();
        for (int i = 0; i < 17; i++) sk_bit(bits[17-i], d);
        bus.EEPROM_DI = bits[0];
        bus.EEPROM_SK = 1'b0;
        bus.HOST_WE = 1'b1; bus.HOST_ADDR = a_h; bus.HOST_WD = d_h;
        repeat (SK_HALF) @(negedge CLK);
        bus.EEPROM_SK = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge CLK);
            if (bus.BUSY_OUT === 1'b1) hit = 1'b1;
        end
        bus.HOST_WE = 1'b0;
        total++;
        if (!hit) begin bad++; $display("FAIL collide_busy_rise: got 0 expected 1"); end
        ref_mem[a_h]  = d_h;
        ref_mem[a_mw] = d_mw;
        wait_not_busy("collide");
        cs_end();
    endtask

    task automatic test_collision();
        logic [7:0] dh, dm;
        mw_write_collide(7'h20, 8'h5A, 7'h20, 8'h00);
        check_host("collide_same", 7'h20);
        dm = 8'($urandom);
        dh = 8'($urandom);
        mw_write_collide(7'h30, dm, 7'h31, dh);
        check_host("collide_mw", 7'h30);
        check_host("collide_host", 7'h31);
    endtask

    task automatic test_abort();
        logic [6:0] a;
        logic d;
        a = 7'h33;
        host_write(a, 8'h5C);
        cs_begin();
        sk_bit(1'b1, d);
        sk_bit(1'b0, d);
        sk_bit(1'b1, d);
        for (int i = 6; i >= 3; i--) sk_bit(a[i], d);
        cs_end();
        total++;
        if (bus.EEPROM_DO !== 1'b1) begin bad++; $display("FAIL abort_do: got %b expected 1", bus.EEPROM_DO); end
        total++;
        if (bus.BUSY_OUT !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b expected 0", bus.BUSY_OUT); end
        check_host("abort", a);
        check_read("after_abort", a, 1);
    endtask

    task automatic test_busy_ignore();
        logic [17:0] bits;
        logic d;
        int eb;
        logic [7:0] dw;
        host_write(7'h40, 8'h12);
        dw = 8'($urandom);
        bits = {1'b1, T_WRITE, 7'h41, dw};
        cs_begin();
        for (int i = 0; i < 18; i++) sk_bit(bits[17-i], d);
        cs_end();
        model_cmd(T_WRITE, 7'h41, dw, eb);
        cs_begin();
        total++;
        if (bus.EEPROM_DO !== 1'b0) begin bad++; $display("FAIL busy_status_do: got %b expected 0", bus.EEPROM_DO); end
        bits = {1'b1, T_ERASE, 7'h40, 8'h00};
        for (int i = 0; i < 10; i++) sk_bit(bits[17-i], d);
        cs_end();
        wait_not_busy("busy_ignore");
        check_host("busy_ignore_erase", 7'h40);
        check_host("busy_ignore_write", 7'h41);
    endtask

    task automatic test_eral();
        logic [17:0] bits;
        logic d;
        int eb, nb, lo, lo_err;
        bit fell;
        bits = {1'b1, T_EXT, A_ERAL, 8'h00};
        model_cmd(T_EXT, A_ERAL, 8'h00, eb);
        cs_begin();
        for (int i = 0; i < 9; i++) sk_bit(bits[17-i], d);
        bus.EEPROM_DI = bits[8];
        bus.EEPROM_SK = 1'b0;
        repeat (SK_HALF) @(negedge CLK);
        bus.EEPROM_SK = 1'b1;
        nb = 0; lo = 0; lo_err = 0; fell = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (bus.BUSY_OUT === 1'b1) begin
                nb++;
                if (bus.EEPROM_DO === 1'b0) lo++;
                else if (i >= 9) lo_err++;
            end else if (nb > 0) begin
                fell = 1'b1;
                total++;
                if (bus.EEPROM_DO !== 1'b1) begin bad++; $display("FAIL eral_ready_do: got %b expected 1", bus.EEPROM_DO); end
                break;
            end
            if (i == 2) begin bus.EEPROM_SK = 1'b0; bus.EEPROM_CS = 1'b0; end
            if (i == 5) bus.EEPROM_CS = 1'b1;
        end
        total++;
        if (!fell || nb != eb) begin bad++; $display("FAIL eral_busy_cycles: got %0d expected %0d", nb, eb); end
        total++;
        if (lo_err != 0) begin bad++; $display("FAIL eral_busy_do: DO high on %0d busy cycles, expected 0", lo_err); end
        total++;
        if (lo < 185 || lo > 200) begin bad++; $display("FAIL eral_do_low_len: got %0d expected 185..200", lo); end
        cs_end();
        for (int i = 0; i < 128; i++) check_host("eral", 7'(i));
    endtask

    task automatic test_random();
        logic [6:0] a, ra;
        logic [7:0] dat;
        int r;
        for (int it = 0; it < 10; it++) begin
            r   = int'($urandom_range(0, 5));
            a   = 7'($urandom);
            dat = 8'($urandom);
            case (r)
                0, 1: do_cmd("rnd_write", T_WRITE, a, dat);
                2:    do_cmd("rnd_erase", T_ERASE, a, dat);
                3:    do_cmd("rnd_ewen", T_EXT, {2'b11, a[4:0]}, dat);
                4:    do_cmd("rnd_ewds", T_EXT, {2'b00, a[4:0]}, dat);
                default: do_cmd("rnd_wral", T_EXT, {2'b01, a[4:0]}, dat);
            endcase
            ra = ($urandom_range(0, 1) == 0) ? a : 7'($urandom);
            check_read("rnd_read", ra, int'($urandom_range(1, 2)));
        end
        do_cmd("rnd_ewen_final", T_EXT, A_EWEN, 8'h00);
        do_cmd("rnd_write_final", T_WRITE, 7'h7E, 8'($urandom));
        check_read("rnd_read_final", 7'h7E, 3);
        do_cmd("rnd_ewds_final", T_EXT, A_EWDS, 8'h00);
        do_cmd("rnd_wral_wp", T_EXT, A_WRAL, 8'h99);
        check_host("rnd_wral_wp", 7'h7E);
    endtask

    initial begin
        test_reset();
        test_wp_default();
        test_write_read();
        test_read_wrap();
        test_collision();
        test_abort();
        test_busy_ignore();
        test_eral();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
